mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, sets the address width of all address ports.
REQ-002 Parameter DATA_W, default 32, sets the width of all data ports.
REQ-003 Parameter TIMEOUT, default 16, sets the watchdog limit in cycles; legal range 2..255.
REQ-004 The ports SHALL be (name, direction, width, meaning):
  clk  in  1  clock, rising edge
  rst  in  1  reset, asynchronous, active-low
  req0  in  1  requester 0 (CPU control unit) access request
  we0  in  1  requester 0 write enable (1 = write, 0 = read)
  addr0  in  ADDR_W  requester 0 address
  wdata0  in  DATA_W  requester 0 write data
  req1  in  1  requester 1 (UART program loader) access request
  we1  in  1  requester 1 write enable
  addr1  in  ADDR_W  requester 1 address
  wdata1  in  DATA_W  requester 1 write data
  ack0  out  1  one-cycle completion pulse to requester 0
  ack1  out  1  one-cycle completion pulse to requester 1
  rdata  out  DATA_W  read data of the completed access
  err  out  1  completed access was aborted by timeout (valid while ack0 or ack1 is high)
  busy  out  1  a transaction is in progress (state not IDLE)
  owner  out  1  index of the current or last granted requester
  mem_req  out  1  memory-map access strobe
  mem_we  out  1  memory-map write enable
  mem_addr  out  ADDR_W  memory-map address
  mem_wdata  out  DATA_W  memory-map write data
  mem_rdata  in  DATA_W  memory-map read data
  mem_ready  in  1  memory-map access complete, sampled only while mem_req is high

Function
REQ-005 The FSM SHALL have exactly three states: IDLE, BUSY, ACK.
REQ-006 In IDLE, at a rising edge with req0 or req1 high, the block SHALL:
  - select one requester;
  - latch that requester's we, addr and wdata into the mem_* output registers;
  - set owner to the selected index;
  - go to BUSY.
REQ-007 Selection SHALL be round-robin.
  - A priority pointer names the preferred requester.
  - If only one request is high, that requester is selected.
  - If both are high, the requester named by the pointer is selected.
  - The pointer SHALL move to the other requester each time a grant is made.
REQ-008 mem_req SHALL be high exactly while the state is BUSY.
  - mem_we, mem_addr and mem_wdata SHALL stay stable for the whole BUSY period.
REQ-009 In BUSY, at a rising edge with mem_ready high, the block SHALL:
  - capture mem_rdata into rdata (on a write, rdata SHALL be loaded with 0);
  - clear err;
  - go to ACK.
REQ-010 In ACK, the owner's ack SHALL be high for exactly one cycle, then the state SHALL return to IDLE; no grant is made while in ACK.
REQ-011 Latency, best case:
  - request sampled at edge N;
  - mem_req high from edge N to edge N+1;
  - with mem_ready high at edge N+1, ack is high from edge N+1 to edge N+2.
REQ-012 A requester SHALL hold req, we, addr and wdata until its ack; a req dropped after the grant SHALL NOT abort the transaction, and ack SHALL still pulse.
REQ-013 rdata and err SHALL hold their values until the next transaction completes.
REQ-014 ack0 and ack1 SHALL never be high in the same cycle.
REQ-015 mem_ready while not in BUSY SHALL be ignored.

Reset
REQ-016 While rst is low, the block SHALL be in IDLE with these values:
  - mem_req, mem_we, ack0, ack1, err, busy and owner all 0;
  - mem_addr, mem_wdata and rdata all 0;
  - priority pointer on requester 0.
REQ-017 Assertion of rst mid-transaction SHALL drop mem_req immediately (asynchronously), with no ack issued.
  - After rst is released, arbitration restarts from IDLE.

Configuration
REQ-018 The macro MEM_PORT_ARBITER_TIMEOUT_EN SHALL control the watchdog.
  - When defined, a cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle without mem_ready.
  - When the counter reaches TIMEOUT without mem_ready, the block SHALL go to ACK with err = 1 and rdata = 0, and mem_req SHALL drop.
  - mem_ready and timeout at the same edge: mem_ready wins, and err = 0.
REQ-019 When MEM_PORT_ARBITER_TIMEOUT_EN is not defined, BUSY SHALL wait indefinitely for mem_ready, err SHALL be constant 0, and no counter logic SHALL be present.

Verification
REQ-020 The bench SHALL cover these directed scenarios (stimulus -> required response):
  - Single read: req0=1, we0=0, addr0=0x10010000; mem_ready=1 one cycle after mem_req with mem_rdata=0xDEADBEEF -> mem_addr=0x10010000, ack0 single pulse, rdata=0xDEADBEEF, ack1 never high.
  - Contention: req0=req1=1 held continuously, immediate mem_ready -> grants alternate 0,1,0,1 across four transactions; owner matches each ack.
  - Write with wait states: req1=1, we1=1, addr1=0x400000, wdata1=0x000000A5; mem_ready delayed 5 cycles -> mem_we=1 and address/data stable for 6 mem_req cycles; ack1 pulse; rdata=0.
  - Mid-transaction reset: rst low while in BUSY -> mem_req=0 immediately, no ack; after release, a pending req1 is granted ahead of a simultaneous req0 only if the pointer says so (pointer = 0 after reset -> req0 first).
  - Timeout (macro defined, TIMEOUT=16): req0 with mem_ready held 0 -> mem_req high 16 cycles, then ack0 with err=1 and rdata=0; without the macro, mem_req stays high and err stays 0.
  - Dropped request: req0 deasserted one cycle after grant -> transaction completes, ack0 still pulses once.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Port bundle for mem_port_arbiter: two requester ports, completion/status
// outputs and the memory-map port. The arbiter uses the slave modport; the
// requesters and memory model use the master modport.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Requester 0 (CPU control unit)
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  // Requester 1 (UART program loader)
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  // Completion and status
  logic              ack0;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              err;
  logic              busy;
  logic              owner;
  // Memory-map port
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata, mem_ready,
    output ack0, ack1, rdata, err, busy, owner,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata, mem_ready,
    input  ack0, ack1, rdata, err, busy, owner,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: two-requester round-robin arbiter in front of a single
// memory-map port. IDLE -> BUSY (mem_req high) -> ACK (one-cycle ack) -> IDLE.
// Optional watchdog enabled by defining MEM_PORT_ARBITER_TIMEOUT_EN: a BUSY
// transaction without mem_ready for TIMEOUT cycles completes with err = 1.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_port_arbiter: TIMEOUT must be in 2..255");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              owner_q, owner_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              gnt_valid;
  logic              gnt_sel;

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
`endif

  // Round-robin pick: a lone request wins, otherwise the pointer decides
  always_comb begin
    gnt_valid = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      gnt_sel = ptr_q;
    end else begin
      gnt_sel = bus.req1;
    end
  end

  // Next-state and register-load decisions
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
    cnt_d       = cnt_q;
    err_d       = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          state_d     = BUSY;
          owner_d     = gnt_sel;
          ptr_d       = ~gnt_sel;
          mem_we_d    = gnt_sel ? bus.we1    : bus.we0;
          mem_addr_d  = gnt_sel ? bus.addr1  : bus.addr0;
          mem_wdata_d = gnt_sel ? bus.wdata1 : bus.wdata0;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUSY: begin
        // mem_ready takes precedence over an expiring watchdog on the same edge
        if (bus.mem_ready) begin
          state_d = ACK;
          rdata_d = mem_we_q ? '0 : bus.mem_rdata;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_d = ACK;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      owner_q     <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  // Watchdog counter and error flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  // mem_req decodes straight from the state flop so reset drops it at once
  assign bus.mem_req   = (state_q == BUSY);
  assign bus.busy      = (state_q != IDLE);
  assign bus.ack0      = (state_q == ACK) && !owner_q;
  assign bus.ack1      = (state_q == ACK) &&  owner_q;
  assign bus.owner     = owner_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter. A driver feeds per-requester
// transaction queues and pushes expected completions; a monitor models the
// round-robin rule, plays the memory, and checks every ack against the queue.
module tb_mem_port_arbiter;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 16;
  localparam int          NEVER   = 100000;
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mrd;
    int          lat;
    bit          drop;
  } txn_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          cycles;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  txn_t pend0[$], pend1[$];
  exp_t exp0[$], exp1[$];
  txn_t cur[2];
  bit   active[2];
  bit   dropped[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic txn_t mk_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [31:0] mrd, input int lat, input bit drop);
    txn_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.mrd = mrd; t.lat = lat; t.drop = drop;
    return t;
  endfunction

  // Expected completion from the transaction's own parameters
  function automatic exp_t mk_exp(input txn_t t);
    exp_t e;
    bit   to;
    to       = TO_EN && (t.lat >= int'(TIMEOUT));
    e.we     = t.we;
    e.addr   = t.addr;
    e.wdata  = t.wdata;
    e.err    = to;
    e.cycles = to ? int'(TIMEOUT) : t.lat + 1;
    e.rdata  = (t.we || to) ? 32'h0 : t.mrd;
    return e;
  endfunction

  // Requester driver: holds each transaction until its ack, optional early drop
  initial begin
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    for (int k = 0; k < 2; k++) begin active[k] = 1'b0; dropped[k] = 1'b0; end
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int k = 0; k < 2; k++) begin active[k] = 1'b0; dropped[k] = 1'b0; end
      end else begin
        if (active[0] && bus.ack0) active[0] = 1'b0;
        if (active[1] && bus.ack1) active[1] = 1'b0;
        for (int k = 0; k < 2; k++)
          if (active[k] && cur[k].drop && bus.mem_req) dropped[k] = 1'b1;
        if (!active[0] && pend0.size() != 0) begin
          cur[0] = pend0.pop_front(); active[0] = 1'b1; dropped[0] = 1'b0;
          exp0.push_back(mk_exp(cur[0]));
        end
        if (!active[1] && pend1.size() != 0) begin
          cur[1] = pend1.pop_front(); active[1] = 1'b1; dropped[1] = 1'b0;
          exp1.push_back(mk_exp(cur[1]));
        end
      end
      bus.req0   = active[0] && !dropped[0];
      bus.we0    = active[0] ? cur[0].we    : 1'($urandom);
      bus.addr0  = active[0] ? cur[0].addr  : $urandom;
      bus.wdata0 = active[0] ? cur[0].wdata : $urandom;
      bus.req1   = active[1] && !dropped[1];
      bus.we1    = active[1] ? cur[1].we    : 1'($urandom);
      bus.addr1  = active[1] ? cur[1].addr  : $urandom;
      bus.wdata1 = active[1] ? cur[1].wdata : $urandom;
    end
  end

  // Request lines as seen at each rising edge
  logic e_r0, e_r1;
  always @(posedge clk) begin
    e_r0 = bus.req0;
    e_r1 = bus.req1;
  end

  // Monitor, round-robin reference and memory responder
  bit          m_ptr, exp_win, in_txn, prev_mreq, stable, k;
  logic        g_we;
  logic [31:0] g_addr, g_wdata, resp_rd;
  int          ncyc, resp_lat;
  exp_t        e;
  initial begin
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    m_ptr = 1'b0; in_txn = 1'b0; prev_mreq = 1'b0; exp_win = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_ptr = 1'b0; in_txn = 1'b0; prev_mreq = 1'b0;
      end else begin
        if (bus.mem_req && !prev_mreq) begin
          if (!(e_r0 || e_r1)) begin
            checks++; errors++;
            $display("FAIL grant_without_request actual=mem_req required=no grant");
          end
          exp_win  = (e_r0 && e_r1) ? m_ptr : e_r1;
          m_ptr    = !exp_win;
          chk("grant_owner", 32'(bus.owner), 32'(exp_win));
          g_we     = bus.mem_we; g_addr = bus.mem_addr; g_wdata = bus.mem_wdata;
          stable   = 1'b1; ncyc = 0; in_txn = 1'b1;
          resp_lat = cur[exp_win].lat; resp_rd = cur[exp_win].mrd;
        end
        if (bus.mem_req) begin
          ncyc++;
          if (bus.mem_we !== g_we || bus.mem_addr !== g_addr || bus.mem_wdata !== g_wdata) stable = 1'b0;
        end
        if (bus.ack0 || bus.ack1) begin
          k = bus.ack1;
          chk("ack_exclusive", 32'(bus.ack0 & bus.ack1), 32'h0);
          chk("ack_in_txn", 32'(in_txn), 32'h1);
          chk("ack_requester", 32'(k), 32'(exp_win));
          chk("ack_owner", 32'(bus.owner), 32'(exp_win));
          if ((k ? exp1.size() : exp0.size()) == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack actual=ack%0d required=no ack", k);
          end else begin
            e = k ? exp1.pop_front() : exp0.pop_front();
            chk("rdata", bus.rdata, e.rdata);
            chk("err", 32'(bus.err), 32'(e.err));
            chk("mem_we", 32'(g_we), 32'(e.we));
            chk("mem_addr", g_addr, e.addr);
            chk("mem_wdata", g_wdata, e.wdata);
            chk("busy_stable", 32'(stable), 32'h1);
            chk("mem_req_cycles", 32'(ncyc), 32'(e.cycles));
          end
          in_txn = 1'b0;
        end
        prev_mreq = bus.mem_req;
      end
      if (rst && bus.mem_req && in_txn && ncyc == resp_lat + 1) begin
        bus.mem_ready = 1'b1; bus.mem_rdata = resp_rd;
      end else begin
        bus.mem_ready = bus.mem_req ? 1'b0 : 1'($urandom_range(0, 1));
        bus.mem_rdata = $urandom;
      end
    end
  end

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((pend0.size() + pend1.size() + exp0.size() + exp1.size()) != 0 ||
           active[0] || active[1] || bus.busy) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        checks++; errors++;
        $display("FAIL %s_drain actual=stalled required=idle within %0d cycles", tag, budget);
        return;
      end
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_mem_req"}, 32'(bus.mem_req), 32'h0);
    chk({tag, "_mem_we"}, 32'(bus.mem_we), 32'h0);
    chk({tag, "_ack"}, 32'({bus.ack1, bus.ack0}), 32'h0);
    chk({tag, "_err"}, 32'(bus.err), 32'h0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_owner"}, 32'(bus.owner), 32'h0);
    chk({tag, "_mem_addr"}, bus.mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'h0);
    chk({tag, "_rdata"}, bus.rdata, 32'h0);
  endtask

  // Directed scenarios followed by randomized traffic
  initial begin
    int n, hi_cnt, err_seen, lat;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    #1 rst = 1'b1;

    // Contention: both held, grants alternate from requester 0
    for (int i = 0; i < 2; i++) begin
      pend0.push_back(mk_txn(1'b0, 32'h100 + 32'(i), $urandom, $urandom, 0, 1'b0));
      pend1.push_back(mk_txn(1'b0, 32'h200 + 32'(i), $urandom, $urandom, 0, 1'b0));
    end
    wait_idle(200, "contention");

    // Single read
    pend0.push_back(mk_txn(1'b0, 32'h1001_0000, 32'h0, 32'hDEAD_BEEF, 1, 1'b0));
    wait_idle(100, "single_read");
    chk("single_read_rdata_hold", bus.rdata, 32'hDEAD_BEEF);

    // Write with five wait states
    pend1.push_back(mk_txn(1'b1, 32'h0040_0000, 32'h0000_00A5, 32'h1234_5678, 5, 1'b0));
    wait_idle(100, "write_wait");

    // Request dropped after the grant still completes
    pend0.push_back(mk_txn(1'b0, 32'h0000_0040, 32'h0, 32'hCAFE_F00D, 2, 1'b1));
    wait_idle(100, "dropped_req");

    // Stalled memory, then reset in the middle of BUSY
    pend0.push_back(mk_txn(1'b0, 32'h0000_0080, 32'h0, 32'h0, NEVER, 1'b0));
    n = 0;
    while (!bus.mem_req && n < 20) begin @(negedge clk); n++; end
    chk("stall_grant", 32'(bus.mem_req), 32'h1);
    if (TO_EN) begin
      repeat (3) @(negedge clk);
    end else begin
      hi_cnt = 0; err_seen = 0;
      repeat (40) begin
        @(negedge clk);
        if (bus.mem_req) hi_cnt++;
        if (bus.err) err_seen++;
      end
      chk("no_watchdog_mem_req_cycles", 32'(hi_cnt), 32'd40);
      chk("no_watchdog_err", 32'(err_seen), 32'h0);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_mem_req", 32'(bus.mem_req), 32'h0);
    chk("async_reset_ack", 32'({bus.ack1, bus.ack0}), 32'h0);
    @(negedge clk);
    exp0.delete(); exp1.delete(); pend0.delete(); pend1.delete();
    @(negedge clk);
    chk_reset_values("mid_reset");
    #1 rst = 1'b1;
    pend1.push_back(mk_txn(1'b0, 32'h0000_1111, 32'h0, $urandom, 0, 1'b0));
    pend0.push_back(mk_txn(1'b0, 32'h0000_2222, 32'h0, $urandom, 0, 1'b0));
    wait_idle(100, "post_reset");

    // Watchdog expiry and the ready-at-last-edge boundary
    if (TO_EN) begin
      pend0.push_back(mk_txn(1'b0, 32'h0000_0300, 32'h0, 32'hFFFF_FFFF, NEVER, 1'b0));
      wait_idle(100, "timeout");
      pend1.push_back(mk_txn(1'b0, 32'h0000_0304, 32'h0, 32'h5555_AAAA, int'(TIMEOUT) - 1, 1'b0));
      wait_idle(100, "timeout_boundary");
    end

    // Randomized traffic
    for (int it = 0; it < 30; it++) begin
      n = int'($urandom_range(1, 3));
      for (int j = 0; j < n; j++) begin
        case ($urandom_range(0, 9))
          0:       lat = int'(TIMEOUT) - 1;
          1:       lat = int'(TIMEOUT);
          default: lat = int'($urandom_range(0, 4));
        endcase
        if ($urandom_range(0, 2) != 0)
          pend0.push_back(mk_txn(1'($urandom), $urandom, $urandom, $urandom, lat, 1'b0));
        if ($urandom_range(0, 2) != 0)
          pend1.push_back(mk_txn(1'($urandom), $urandom, $urandom, $urandom, lat, 1'b0));
      end
      wait_idle(800, "random");
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit
  initial begin
    #3_000_000;
    $display("FAIL global_timeout actual=running required=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
